laser_frame_feeder: RTL and testbench

- Upstream stage of the LASER circle-placement engine.
- Accepts 40-point frames from a host over a valid/ready handshake and double-buffers them in two banks.
- Streams each frame into the engine at one point per cycle, in the exact cycle window the engine's load phase expects.
- Owns the engine's reset (LRST) and captures the engine's C1/C2 result when it pulses DONE, presenting it on a valid/ready result port.

---
 rtl/laser_frame_feeder.sv | 146 ++++++++++++++
 tb/tb_laser_frame_feeder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_frame_feeder.sv
// Double-buffered point feeder for the LASER engine: owns LRST, streams 40-point frames, captures results.
// Optional FEEDER_FRAME_CNT_EN adds an 8-bit wrapping count of captured results on frame_cnt.
module laser_frame_feeder #(
  parameter int NPTS = 40,
  parameter int DW   = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_x,
  input  logic [DW-1:0] in_y,
  output logic          LRST,
  output logic [DW-1:0] LX,
  output logic [DW-1:0] LY,
  input  logic          LDONE,
  input  logic [DW-1:0] LC1X,
  input  logic [DW-1:0] LC1Y,
  input  logic [DW-1:0] LC2X,
  input  logic [DW-1:0] LC2Y,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_c1x,
  output logic [DW-1:0] res_c1y,
  output logic [DW-1:0] res_c2x,
  output logic [DW-1:0] res_c2y,
  output logic          res_ovf
`ifdef FEEDER_FRAME_CNT_EN
  ,
  output logic [7:0]    frame_cnt
`endif
);

  localparam int AW = $clog2(NPTS + 1);
  localparam logic [AW-1:0] LAST_PT  = AW'(NPTS - 1);
  localparam logic [AW-1:0] PAST_END = AW'(NPTS);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT} state_t;

  logic [2*DW-1:0] bank [2][NPTS];
  logic [1:0]      full;
  logic            wb;
  logic            rb;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   idx;
  state_t          state;
  logic            wr;
  logic            cap;

  assign in_ready = !full[wb];
  assign wr       = in_valid && in_ready;
  assign cap      = (state == WAIT) && LDONE;

  always_ff @(posedge CLK) begin
    if (wr) bank[wb][wptr] <= {in_x, in_y};
  end

  // Write side fills bank wb; the FSM drains bank rb. They never touch the same full bit on one edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      full      <= 2'b00;
      wb        <= 1'b0;
      rb        <= 1'b0;
      wptr      <= '0;
      idx       <= '0;
      state     <= IDLE;
      LRST      <= 1'b1;
      LX        <= '0;
      LY        <= '0;
      res_valid <= 1'b0;
      res_ovf   <= 1'b0;
      res_c1x   <= '0;
      res_c1y   <= '0;
      res_c2x   <= '0;
      res_c2y   <= '0;
`ifdef FEEDER_FRAME_CNT_EN
      frame_cnt <= 8'd0;
`endif
    end else begin
      if (wr) begin
        if (wptr == LAST_PT) begin
          wptr     <= '0;
          full[wb] <= 1'b1;
          wb       <= ~wb;
        end else begin
          wptr <= wptr + AW'(1);
        end
      end

      case (state)
        IDLE: begin
          LRST <= 1'b1;
          LX   <= '0;
          LY   <= '0;
          if (full[rb]) begin
            LRST     <= 1'b0;
            {LX, LY} <= bank[rb][0];
            idx      <= AW'(1);
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (idx == PAST_END) begin
            full[rb] <= 1'b0;
            rb       <= ~rb;
            LX       <= '0;
            LY       <= '0;
            state    <= WAIT;
          end else begin
            {LX, LY} <= bank[rb][idx];
            idx      <= idx + AW'(1);
          end
        end
        WAIT: begin
          // Point 0 registered on the DONE edge lands in the engine's first load cycle.
          if (LDONE) begin
            if (full[rb]) begin
              {LX, LY} <= bank[rb][0];
              idx      <= AW'(1);
              state    <= STREAM;
            end else begin
              LRST  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (cap) begin
        res_c1x   <= LC1X;
        res_c1y   <= LC1Y;
        res_c2x   <= LC2X;
        res_c2y   <= LC2Y;
        res_valid <= 1'b1;
        if (res_valid && !res_ready) res_ovf <= 1'b1;
`ifdef FEEDER_FRAME_CNT_EN
        frame_cnt <= frame_cnt + 8'd1;
`endif
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_laser_frame_feeder.sv
// Directed bench for laser_frame_feeder: frame streaming, double buffering, result capture, overflow, reset.
module tb_laser_frame_feeder;

  logic       CLK;
  logic       RST;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_x;
  logic [3:0] in_y;
  logic       LRST;
  logic [3:0] LX;
  logic [3:0] LY;
  logic       LDONE;
  logic [3:0] LC1X;
  logic [3:0] LC1Y;
  logic [3:0] LC2X;
  logic [3:0] LC2Y;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_c1x;
  logic [3:0] res_c1y;
  logic [3:0] res_c2x;
  logic [3:0] res_c2y;
  logic       res_ovf;
`ifdef FEEDER_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  int passed = 0;
  int total  = 0;

  laser_frame_feeder #(.NPTS(40), .DW(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .LRST      (LRST),
    .LX        (LX),
    .LY        (LY),
    .LDONE     (LDONE),
    .LC1X      (LC1X),
    .LC1Y      (LC1Y),
    .LC2X      (LC2X),
    .LC2Y      (LC2Y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_c1x   (res_c1x),
    .res_c1y   (res_c1y),
    .res_c2x   (res_c2x),
    .res_c2y   (res_c2y),
    .res_ovf   (res_ovf)
`ifdef FEEDER_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [3:0] px(int f, int k);
    case (f)
      0:       return 4'(k % 16);
      1:       return 4'((k + 5) % 16);
      2:       return 4'((5 * k + 3) % 16);
      default: return 4'((k + 11) % 16);
    endcase
  endfunction

  function automatic logic [3:0] py(int f, int k);
    case (f)
      0:       return 4'((3 * k) % 16);
      1:       return 4'((7 * k + 2) % 16);
      2:       return 4'((k + 9) % 16);
      default: return 4'((13 * k + 4) % 16);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input int expected);
    total++;
    assert (observed === 8'(expected)) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, 8'(expected));
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] x, input logic [3:0] y);
    in_valid = v;
    in_x     = x;
    in_y     = y;
  endtask

  task automatic setResult(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    LC1X = a;
    LC1Y = b;
    LC2X = c;
    LC2Y = d;
  endtask

  task automatic checkPoint(input string tag, input int k, input logic [3:0] ex, input logic [3:0] ey);
    checkOutput($sformatf("%s pt%0d LRST", tag, k), LRST, 0);
    checkOutput($sformatf("%s pt%0d LX", tag, k), LX, ex);
    checkOutput($sformatf("%s pt%0d LY", tag, k), LY, ey);
  endtask

  // All inputs change and all outputs are sampled on the falling edge.
  initial begin
    RST = 1'b1;
    LDONE = 1'b0;
    res_ready = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0);
    setResult(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (2) @(negedge CLK);
    checkOutput("reset LRST", LRST, 1);
    checkOutput("reset LX", LX, 0);
    checkOutput("reset LY", LY, 0);
    checkOutput("reset res_valid", res_valid, 0);
    checkOutput("reset res_ovf", res_ovf, 0);
    checkOutput("reset res_c1x", res_c1x, 0);
    checkOutput("reset in_ready", in_ready, 1);
    RST = 1'b0;

    $display("[TB] single frame load and stream");
    for (int k = 0; k < 40; k++) begin
      checkOutput($sformatf("f0 in_ready w%0d", k), in_ready, 1);
      applyStimulus(1'b1, px(0, k), py(0, k));
      @(negedge CLK);
    end
    applyStimulus(1'b0, 4'd0, 4'd0);
    checkOutput("f0 LRST before stream", LRST, 1);
    @(negedge CLK);
    for (int k = 0; k < 40; k++) begin
      checkPoint("f0", k, px(0, k), py(0, k));
      @(negedge CLK);
    end
    checkOutput("f0 wait LX", LX, 0);
    for (int i = 0; i < 50; i++) begin
      checkOutput($sformatf("f0 wait LRST c%0d", i), LRST, 0);
      @(negedge CLK);
    end
    checkOutput("f0 res_valid before done", res_valid, 0);
    LDONE = 1'b1;
    setResult(4'd5, 4'd6, 4'd9, 4'd10);
    @(negedge CLK);
    LDONE = 1'b0;
    checkOutput("r0 res_valid", res_valid, 1);
    checkOutput("r0 res_c1x", res_c1x, 5);
    checkOutput("r0 res_c1y", res_c1y, 6);
    checkOutput("r0 res_c2x", res_c2x, 9);
    checkOutput("r0 res_c2y", res_c2y, 10);
    checkOutput("r0 res_ovf", res_ovf, 0);
    checkOutput("r0 LRST back to idle", LRST, 1);
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    checkOutput("r0 consumed res_valid", res_valid, 0);
    checkOutput("idle LRST", LRST, 1);

    $display("[TB] two preloaded frames and a blocked write");
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (c == 40) checkOutput("dbl LRST before stream", LRST, 1);
      if (c >= 41) checkPoint("dbl f0", c - 41, px(0, c - 41), py(0, c - 41));
      checkOutput($sformatf("dbl in_ready w%0d", c), in_ready, 1);
      if (c < 40) applyStimulus(1'b1, px(0, c), py(0, c));
      else        applyStimulus(1'b1, px(1, c - 40), py(1, c - 40));
      @(negedge CLK);
    end
    checkPoint("dbl f0", 39, px(0, 39), py(0, 39));
    checkOutput("both full in_ready", in_ready, 0);
    applyStimulus(1'b1, 4'hA, 4'hB);
    @(negedge CLK);
    checkOutput("bank0 freed in_ready", in_ready, 1);
    checkOutput("dbl wait LRST", LRST, 0);
    checkOutput("dbl wait LX", LX, 0);
    @(negedge CLK);
    applyStimulus(1'b0, 4'd0, 4'd0);
    checkOutput("after late write in_ready", in_ready, 1);
    repeat (3) @(negedge CLK);
    LDONE = 1'b1;
    setResult(4'd1, 4'd2, 4'd3, 4'd4);
    @(negedge CLK);
    LDONE = 1'b0;
    checkOutput("r1 res_valid", res_valid, 1);
    checkOutput("r1 res_c1x", res_c1x, 1);
    checkOutput("r1 res_c2y", res_c2y, 4);
    checkOutput("r1 res_ovf", res_ovf, 0);
    for (int k = 0; k < 40; k++) begin
      checkPoint("f1", k, px(1, k), py(1, k));
      @(negedge CLK);
    end
    checkOutput("f1 wait LX", LX, 0);
    checkOutput("f1 wait LRST", LRST, 0);
    for (int k = 1; k < 40; k++) begin
      checkOutput($sformatf("f2 in_ready w%0d", k), in_ready, 1);
      applyStimulus(1'b1, px(2, k), py(2, k));
      @(negedge CLK);
    end
    applyStimulus(1'b0, 4'd0, 4'd0);
    checkOutput("f2 loaded in_ready", in_ready, 1);
    checkOutput("f2 loaded LRST", LRST, 0);

    $display("[TB] overwrite of unconsumed result");
    LDONE = 1'b1;
    setResult(4'd7, 4'd8, 4'd11, 4'd12);
    @(negedge CLK);
    LDONE = 1'b0;
    checkOutput("r2 res_valid", res_valid, 1);
    checkOutput("r2 res_c1x", res_c1x, 7);
    checkOutput("r2 res_c1y", res_c1y, 8);
    checkOutput("r2 res_c2x", res_c2x, 11);
    checkOutput("r2 res_c2y", res_c2y, 12);
    checkOutput("r2 res_ovf", res_ovf, 1);
`ifdef FEEDER_FRAME_CNT_EN
    checkOutput("r2 frame_cnt", frame_cnt, 2);
`endif
    checkPoint("f2", 0, 4'hA, 4'hB);
    for (int k = 1; k < 40; k++) begin
      @(negedge CLK);
      checkPoint("f2", k, px(2, k), py(2, k));
    end
    @(negedge CLK);
    checkOutput("f2 wait LX", LX, 0);
    checkOutput("f2 wait LRST", LRST, 0);
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    checkOutput("r2 consumed res_valid", res_valid, 0);
    checkOutput("r2 consumed res_ovf sticky", res_ovf, 1);

    $display("[TB] frame completes on the DONE edge");
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, px(3, k), py(3, k));
      if (k == 39) begin
        LDONE = 1'b1;
        setResult(4'd13, 4'd14, 4'd15, 4'd0);
      end
      @(negedge CLK);
    end
    applyStimulus(1'b0, 4'd0, 4'd0);
    LDONE = 1'b0;
    checkOutput("sim LRST idle", LRST, 1);
    checkOutput("sim LX", LX, 0);
    checkOutput("sim in_ready", in_ready, 1);
    checkOutput("r3 res_valid", res_valid, 1);
    checkOutput("r3 res_c1x", res_c1x, 13);
    checkOutput("r3 res_c2y", res_c2y, 0);
    checkOutput("r3 res_ovf", res_ovf, 1);
    @(negedge CLK);
    checkPoint("f3", 0, px(3, 0), py(3, 0));
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      checkPoint("f3", k, px(3, k), py(3, k));
    end

    $display("[TB] reset mid-stream");
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checkOutput("midrst LRST", LRST, 1);
    checkOutput("midrst LX", LX, 0);
    checkOutput("midrst LY", LY, 0);
    checkOutput("midrst in_ready", in_ready, 1);
    checkOutput("midrst res_valid", res_valid, 0);
    checkOutput("midrst res_ovf", res_ovf, 0);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, px(0, k), py(0, k));
      @(negedge CLK);
    end
    applyStimulus(1'b0, 4'd0, 4'd0);
    checkOutput("fresh LRST before stream", LRST, 1);
    @(negedge CLK);
    for (int k = 0; k < 40; k++) begin
      checkPoint("fresh", k, px(0, k), py(0, k));
      @(negedge CLK);
    end
    checkOutput("fresh wait LX", LX, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
